// File: rtl/mdc_commutator.sv
// mdc_commutator: delay / 2x2 switch / delay reordering stage between two radix-2 MDC FFT butterflies.
// Optional feature: define COMM_SOF_OUT_EN to add the do_sof output.
module mdc_commutator #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 9
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    di_valid,
    input  logic                    di_sof,
    input  logic signed [WIDTH-1:0] di0_re,
    input  logic signed [WIDTH-1:0] di0_im,
    input  logic signed [WIDTH-1:0] di1_re,
    input  logic signed [WIDTH-1:0] di1_im,
    output logic                    do_valid,
`ifdef COMM_SOF_OUT_EN
    output logic                    do_sof,
`endif
    output logic signed [WIDTH-1:0] do0_re,
    output logic signed [WIDTH-1:0] do0_im,
    output logic signed [WIDTH-1:0] do1_re,
    output logic signed [WIDTH-1:0] do1_im
);

    localparam int CNT_W  = $clog2(2 * DEPTH);
    localparam int FILL_W = CNT_W + 1;
    localparam logic [FILL_W-1:0] FULL = FILL_W'(2 * DEPTH);

    logic [CNT_W-1:0]        r_cnt;
    logic [FILL_W-1:0]       r_fill;
    logic signed [WIDTH-1:0] r_a_re_p0 [DEPTH];
    logic signed [WIDTH-1:0] r_a_im_p0 [DEPTH];
    logic signed [WIDTH-1:0] r_y_re_p0 [DEPTH];
    logic signed [WIDTH-1:0] r_y_im_p0 [DEPTH];
    logic signed [WIDTH-1:0] r_do0_re_p1, r_do0_im_p1, r_do1_re_p1, r_do1_im_p1;
    logic                    r_vld_p1;

    logic [CNT_W-1:0]        w_cnt_eff;
    logic                    w_sel_p0;
    logic                    w_full_p0;
    logic signed [WIDTH-1:0] w_x_re_p0, w_x_im_p0, w_y_re_p0, w_y_im_p0;

    // Stage p0: sof realigns the period on the very sample that carries it
    always_comb begin
        w_cnt_eff = di_sof ? '0 : r_cnt;
        w_sel_p0  = w_cnt_eff[CNT_W-1];
        w_full_p0 = (r_fill == FULL);
        w_x_re_p0 = r_a_re_p0[DEPTH-1];
        w_x_im_p0 = r_a_im_p0[DEPTH-1];
        w_y_re_p0 = di1_re;
        w_y_im_p0 = di1_im;
        if (w_sel_p0) begin
            w_x_re_p0 = di1_re;
            w_x_im_p0 = di1_im;
            w_y_re_p0 = r_a_re_p0[DEPTH-1];
            w_y_im_p0 = r_a_im_p0[DEPTH-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_fill <= '0;
        end else if (di_valid) begin
            r_cnt <= w_cnt_eff + 1'b1;
            if (!w_full_p0) r_fill <= r_fill + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_a_re_p0[i] <= '0;
                r_a_im_p0[i] <= '0;
                r_y_re_p0[i] <= '0;
                r_y_im_p0[i] <= '0;
            end
        end else if (di_valid) begin
            r_a_re_p0[0] <= di0_re;
            r_a_im_p0[0] <= di0_im;
            r_y_re_p0[0] <= w_y_re_p0;
            r_y_im_p0[0] <= w_y_im_p0;
            for (int i = 1; i < DEPTH; i++) begin
                r_a_re_p0[i] <= r_a_re_p0[i-1];
                r_a_im_p0[i] <= r_a_im_p0[i-1];
                r_y_re_p0[i] <= r_y_re_p0[i-1];
                r_y_im_p0[i] <= r_y_im_p0[i-1];
            end
        end
    end

    // Stage p1: registered outputs, data held across stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_do0_re_p1 <= '0;
            r_do0_im_p1 <= '0;
            r_do1_re_p1 <= '0;
            r_do1_im_p1 <= '0;
            r_vld_p1    <= 1'b0;
        end else begin
            r_vld_p1 <= di_valid & w_full_p0;
            if (di_valid) begin
                r_do0_re_p1 <= w_x_re_p0;
                r_do0_im_p1 <= w_x_im_p0;
                r_do1_re_p1 <= r_y_re_p0[DEPTH-1];
                r_do1_im_p1 <= r_y_im_p0[DEPTH-1];
            end
        end
    end

    assign do_valid = r_vld_p1;
    assign do0_re   = r_do0_re_p1;
    assign do0_im   = r_do0_im_p1;
    assign do1_re   = r_do1_re_p1;
    assign do1_im   = r_do1_im_p1;

`ifdef COMM_SOF_OUT_EN
    logic [2*DEPTH-1:0] r_sof_dl;
    logic               r_sof_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sof_dl <= '0;
            r_sof_p1 <= 1'b0;
        end else begin
            r_sof_p1 <= di_valid & w_full_p0 & r_sof_dl[2*DEPTH-1];
            if (di_valid) r_sof_dl <= {r_sof_dl[2*DEPTH-2:0], di_sof};
        end
    end

    assign do_sof = r_sof_p1;
`endif

endmodule

// File: tb/tb_mdc_commutator.sv
// Directed and randomised bench for mdc_commutator: DEPTH=2 hand vectors plus a DEPTH=16 reference model.
// Exercises do_sof when COMM_SOF_OUT_EN is defined.
module tb_mdc_commutator;

    logic clk;
    logic rst_n;
    int   nvec;
    int   nerr;

    logic              v2, s2;
    logic signed [8:0] a2_re, a2_im, b2_re, b2_im;
    logic              o2_vld;
    logic signed [8:0] o2_0re, o2_0im, o2_1re, o2_1im;
`ifdef COMM_SOF_OUT_EN
    logic              o2_sof;
    logic              o16_sof;
`endif

    logic              v16, s16;
    logic signed [8:0] a16_re, a16_im, b16_re, b16_im;
    logic              o16_vld;
    logic signed [8:0] o16_0re, o16_0im, o16_1re, o16_1im;

    mdc_commutator #(.DEPTH(2), .WIDTH(9)) dut2 (
        .clk(clk), .rst_n(rst_n), .di_valid(v2), .di_sof(s2),
        .di0_re(a2_re), .di0_im(a2_im), .di1_re(b2_re), .di1_im(b2_im),
        .do_valid(o2_vld),
`ifdef COMM_SOF_OUT_EN
        .do_sof(o2_sof),
`endif
        .do0_re(o2_0re), .do0_im(o2_0im), .do1_re(o2_1re), .do1_im(o2_1im)
    );

    mdc_commutator #(.DEPTH(16), .WIDTH(9)) dut16 (
        .clk(clk), .rst_n(rst_n), .di_valid(v16), .di_sof(s16),
        .di0_re(a16_re), .di0_im(a16_im), .di1_re(b16_re), .di1_im(b16_im),
        .do_valid(o16_vld),
`ifdef COMM_SOF_OUT_EN
        .do_sof(o16_sof),
`endif
        .do0_re(o16_0re), .do0_im(o16_0im), .do1_re(o16_1re), .do1_im(o16_1im)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one DEPTH=2 cycle (imag parts are the negated real parts), then sample 1 after the edge.
    task automatic step2(input int a, input int b, input bit sof, input bit vld);
        v2    = vld;
        s2    = sof;
        a2_re = 9'(a);
        a2_im = 9'(-a);
        b2_re = 9'(b);
        b2_im = 9'(-b);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        v2  = 1'b0;
        s2  = 1'b0;
        v16 = 1'b0;
        s16 = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Expected outputs of the regular A=t, B=100+t stream with sof only at t=0.
    function automatic int ex0(input int t);
        return ((t % 4) < 2) ? t - 2 : 100 + t;
    endfunction

    function automatic int ex1(input int t);
        return ((t % 4) < 2) ? t - 4 : 98 + t;
    endfunction

    task automatic test_reset();
        logic [35:0] got;
        rst_n = 1'b0;
        v2 = 1'b1; s2 = 1'b0; a2_re = 9'd5; a2_im = 9'd5; b2_re = 9'd7; b2_im = 9'd7;
        #1;
        got = {o2_0re, o2_0im, o2_1re, o2_1im};
        nvec++;
        if (o2_vld !== 1'b0) begin nerr++; $display("FAIL reset_valid got %b want 0", o2_vld); end
        nvec++;
        if (got !== 36'd0) begin nerr++; $display("FAIL reset_data got %h want 0", got); end
        nvec++;
        if ({o16_vld, o16_0re, o16_1im} !== 19'd0) begin
            nerr++; $display("FAIL reset_d16 got %h want 0", {o16_vld, o16_0re, o16_1im});
        end
        do_reset();
    endtask

    task automatic test_stream();
        logic [35:0] got, exp;
        do_reset();
        for (int t = 0; t < 12; t++) begin
            step2(t, 100 + t, t == 0, 1'b1);
            nvec++;
            if (o2_vld !== (t >= 4)) begin nerr++; $display("FAIL stream_valid t=%0d got %b want %b", t, o2_vld, t >= 4); end
            if (t >= 4) begin
                got = {o2_0re, o2_0im, o2_1re, o2_1im};
                exp = {9'(ex0(t)), 9'(-ex0(t)), 9'(ex1(t)), 9'(-ex1(t))};
                nvec++;
                if (got !== exp) begin nerr++; $display("FAIL stream_data t=%0d got %h want %h", t, got, exp); end
            end
        end
    endtask

    task automatic test_stall();
        logic [35:0] got, exp;
        do_reset();
        for (int t = 0; t < 12; t++) begin
            step2(t, 100 + t, t == 0, 1'b1);
            nvec++;
            if (o2_vld !== (t >= 4)) begin nerr++; $display("FAIL stall_valid t=%0d got %b want %b", t, o2_vld, t >= 4); end
            if (t >= 4) begin
                got = {o2_0re, o2_0im, o2_1re, o2_1im};
                exp = {9'(ex0(t)), 9'(-ex0(t)), 9'(ex1(t)), 9'(-ex1(t))};
                nvec++;
                if (got !== exp) begin nerr++; $display("FAIL stall_data t=%0d got %h want %h", t, got, exp); end
            end
            if (t == 5) begin
                for (int g = 0; g < 3; g++) begin
                    step2(77, 77, 1'b1, 1'b0);
                    got = {o2_0re, o2_0im, o2_1re, o2_1im};
                    exp = {9'sd3, -9'sd3, 9'sd1, -9'sd1};
                    nvec++;
                    if (o2_vld !== 1'b0) begin nerr++; $display("FAIL stall_gap_valid g=%0d got %b want 0", g, o2_vld); end
                    nvec++;
                    if (got !== exp) begin nerr++; $display("FAIL stall_hold g=%0d got %h want %h", g, got, exp); end
                end
            end
        end
    endtask

    task automatic test_resync();
        int rx0 [9] = '{6, 7, 8, 111, 112, 11, 12, 115, 116};
        int rx1 [9] = '{4, 5, 108, 109, 110, 9, 10, 113, 114};
        logic [35:0] got, exp;
        do_reset();
        for (int t = 0; t < 17; t++) begin
            step2(t, 100 + t, (t == 0) || (t == 9), 1'b1);
            if (t >= 8) begin
                got = {o2_0re, o2_0im, o2_1re, o2_1im};
                exp = {9'(rx0[t-8]), 9'(-rx0[t-8]), 9'(rx1[t-8]), 9'(-rx1[t-8])};
                nvec++;
                if (o2_vld !== 1'b1) begin nerr++; $display("FAIL resync_valid t=%0d got %b want 1", t, o2_vld); end
                nvec++;
                if (got !== exp) begin nerr++; $display("FAIL resync_data t=%0d got %h want %h", t, got, exp); end
            end
        end
    endtask

    task automatic test_async_reset();
        logic [36:0] got;
        do_reset();
        for (int t = 0; t < 6; t++) step2(t, 100 + t, t == 0, 1'b1);
        v2 = 1'b1; a2_re = 9'd6; b2_re = 9'd106;
        #2;
        rst_n = 1'b0;
        #1;
        got = {o2_vld, o2_0re, o2_0im, o2_1re, o2_1im};
        nvec++;
        if (got !== 37'd0) begin nerr++; $display("FAIL async_reset_now got %h want 0", got); end
        @(posedge clk);
        @(posedge clk);
        #1;
        got = {o2_vld, o2_0re, o2_0im, o2_1re, o2_1im};
        nvec++;
        if (got !== 37'd0) begin nerr++; $display("FAIL async_reset_hold got %h want 0", got); end
        rst_n = 1'b1;
        for (int t = 0; t < 5; t++) begin
            step2(t, 100 + t, t == 0, 1'b1);
            nvec++;
            if (o2_vld !== (t == 4)) begin nerr++; $display("FAIL reprime_valid t=%0d got %b want %b", t, o2_vld, t == 4); end
        end
        got = {1'b1, o2_0re, o2_0im, o2_1re, o2_1im};
        nvec++;
        if (got !== {1'b1, 9'sd2, -9'sd2, 9'sd0, 9'sd0}) begin
            nerr++; $display("FAIL reprime_data got %h want %h", got, {1'b1, 9'sd2, -9'sd2, 9'sd0, 9'sd0});
        end
    endtask

`ifdef COMM_SOF_OUT_EN
    task automatic test_sof_out();
        do_reset();
        for (int t = 0; t < 14; t++) begin
            step2(t, 100 + t, (t == 0) || (t == 8), 1'b1);
            nvec++;
            if (o2_sof !== ((t == 4) || (t == 12))) begin
                nerr++; $display("FAIL sof_out t=%0d got %b want %b", t, o2_sof, (t == 4) || (t == 12));
            end
        end
    endtask
`endif

    task automatic test_depth16_random();
        logic signed [8:0] ar [200];
        logic signed [8:0] ai [200];
        logic signed [8:0] br [200];
        logic signed [8:0] bi [200];
        logic [35:0] got, exp;
        logic signed [8:0] xr, xi, yr, yi;
        int u;
        for (int t = 0; t < 200; t++) begin
            ar[t] = 9'($urandom);
            ai[t] = 9'($urandom);
            br[t] = 9'($urandom);
            bi[t] = 9'($urandom);
            if (t % 7 == 0)  ar[t] = -9'sd256;
            if (t % 13 == 5) ai[t] = 9'sd255;
            if (t % 5 == 2)  br[t] = -9'sd256;
            if (t % 11 == 3) bi[t] = 9'sd255;
        end
        do_reset();
        for (int t = 0; t < 200; t++) begin
            v16 = 1'b1; s16 = (t == 0);
            a16_re = ar[t]; a16_im = ai[t]; b16_re = br[t]; b16_im = bi[t];
            @(posedge clk);
            #1;
            if (t < 32) begin
                nvec++;
                if (o16_vld !== 1'b0) begin nerr++; $display("FAIL d16_prime t=%0d got %b want 0", t, o16_vld); end
            end else begin
                if (((t / 16) % 2) == 1) begin xr = br[t]; xi = bi[t]; end
                else begin xr = ar[t-16]; xi = ai[t-16]; end
                u = t - 16;
                if (((u / 16) % 2) == 1) begin yr = ar[u-16]; yi = ai[u-16]; end
                else begin yr = br[u]; yi = bi[u]; end
                got = {o16_0re, o16_0im, o16_1re, o16_1im};
                exp = {xr, xi, yr, yi};
                nvec++;
                if ((o16_vld !== 1'b1) || (got !== exp)) begin
                    nerr++; $display("FAIL d16_data t=%0d got %b/%h want 1/%h", t, o16_vld, got, exp);
                end
            end
        end
        v16 = 1'b0;
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        rst_n = 1'b1;
        v2 = 1'b0; s2 = 1'b0; a2_re = '0; a2_im = '0; b2_re = '0; b2_im = '0;
        v16 = 1'b0; s16 = 1'b0; a16_re = '0; a16_im = '0; b16_re = '0; b16_im = '0;
        #3;
        test_reset();
        test_stream();
        test_stall();
        test_resync();
        test_async_reset();
`ifdef COMM_SOF_OUT_EN
        test_sof_out();
`endif
        test_depth16_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
